// File: rtl/i2c_pkg.sv
// Shared I2C types: transfer direction, byte-controller commands and the
// transfer sequencer state encoding.
package i2c_pkg;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_WR    = 3'd3,
        S_RD    = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } i2c_seq_state_t;

endpackage

// File: rtl/i2c_xfer_sequencer_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping around. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // scan from ptr upward with wrap, first hit wins
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Transfer sequencer sharing one byte-level I2C controller between requesters.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrate; grant latches the descriptor
// START   | issue START condition
// ADDR    | write {addr, op}; NACK or zero length ends the transfer
// WR      | write one data byte per visit, popping the owner's wdata
// RD      | read one byte per visit, NAK on the last
// STOP    | issue STOP condition
// DONE    | report done/err to owner, clear sticky error
//
// Each command state first loads cmd/cmd_data (cmd_valid low), then holds
// cmd_valid until accepted, then waits for the response unless it arrived
// together with the accept.
import i2c_pkg::*;

module i2c_xfer_sequencer #(
    parameter int NUM_REQ        = 2,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]                   req_op,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]         req_len,
    input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]                   wdata_pop,
    output logic [I2C_DATA_WIDTH-1:0]            rd_data,
    output logic [NUM_REQ-1:0]                   rd_valid,
    output logic [NUM_REQ-1:0]                   done,
    output logic                                 err,
    output logic                                 cmd_valid,
    output i2c_cmd_t                             cmd,
    output logic [I2C_DATA_WIDTH-1:0]            cmd_data,
    input  logic                                 cmd_ready,
    input  logic                                 rsp_valid,
    input  logic                                 rsp_ack,
    input  logic [I2C_DATA_WIDTH-1:0]            rsp_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = I2C_DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    i2c_seq_state_t            state;
    logic [NUM_REQ-1:0]        arb_grant;
    logic                      arb_valid;
    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             gidx;
    logic [NUM_REQ-1:0]        own;
    logic [PW-1:0]             own_idx;
    logic [I2C_ADDR_WIDTH-1:0] addr_q;
    i2c_op_t                   op_q;
    logic [LEN_WIDTH-1:0]      cnt;
    logic                      err_flag;
    logic                      waiting;
    logic                      rsp_take;
    i2c_cmd_t                  next_cmd;
    logic [DW-1:0]             next_data;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // one-hot grant to index
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_grant[i]) gidx = PW'(i);
    end

    // command and byte to load on entry to each command state
    always_comb begin
        next_cmd  = CMD_START;
        next_data = '0;
        case (state)
            S_ADDR: begin
                next_cmd  = CMD_WRITE;
                next_data = DW'({addr_q, op_q});
            end
            S_WR: begin
                next_cmd  = CMD_WRITE;
                next_data = req_wdata[own_idx*DW +: DW];
            end
            S_RD:    next_cmd = (cnt == LEN_ONE) ? CMD_READ_NAK : CMD_READ_ACK;
            S_STOP:  next_cmd = CMD_STOP;
            default: ;
        endcase
    end

    // a response only counts once the command has been accepted
    assign rsp_take  = rsp_valid && ((cmd_valid && cmd_ready) || waiting);
    // gated by rst so nothing is granted while the block is held in reset
    assign req_ready = (!rst && state == S_IDLE && arb_valid) ? arb_grant : '0;
    assign wdata_pop = (state == S_WR && cmd_valid && cmd_ready) ? own : '0;

    // transfer FSM with descriptor, counter and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            own       <= '0;
            own_idx   <= '0;
            addr_q    <= '0;
            op_q      <= I2C_WRITE;
            cnt       <= '0;
            err_flag  <= 1'b0;
            waiting   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_START;
            cmd_data  <= '0;
            rd_data   <= '0;
            rd_valid  <= '0;
            done      <= '0;
            err       <= 1'b0;
        end else begin
            rd_valid <= '0;
            done     <= '0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        own       <= arb_grant;
                        own_idx   <= gidx;
                        addr_q    <= req_addr[gidx*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
                        op_q      <= i2c_op_t'(req_op[gidx]);
                        cnt       <= req_len[gidx*LEN_WIDTH +: LEN_WIDTH];
                        rr_ptr    <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        cmd_valid <= 1'b1;
                        cmd       <= CMD_START;
                        cmd_data  <= '0;
                        state     <= S_START;
                    end
                end
                S_START, S_ADDR, S_WR, S_RD, S_STOP: begin
                    if (!cmd_valid && !waiting) begin
                        cmd_valid <= 1'b1;
                        cmd       <= next_cmd;
                        cmd_data  <= next_data;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (!rsp_valid) waiting <= 1'b1;
                    end
                    if (rsp_take) begin
                        waiting <= 1'b0;
                        case (state)
                            S_START: state <= S_ADDR;
                            S_ADDR: begin
                                if (!rsp_ack) begin
                                    err_flag <= 1'b1;
                                    state    <= S_STOP;
                                end else if (cnt == '0) begin
                                    state <= S_STOP;
                                end else begin
                                    state <= (op_q == I2C_READ) ? S_RD : S_WR;
                                end
                            end
                            S_WR: begin
                                cnt <= cnt - LEN_ONE;
                                if (!rsp_ack) begin
                                    err_flag <= 1'b1;
                                    state    <= S_STOP;
                                end else if (cnt == LEN_ONE) begin
                                    state <= S_STOP;
                                end
                            end
                            S_RD: begin
                                rd_valid <= own;
                                rd_data  <= rsp_data;
                                cnt      <= cnt - LEN_ONE;
                                if (cnt == LEN_ONE) state <= S_STOP;
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_DONE: begin
                    done     <= own;
                    err      <= err_flag;
                    err_flag <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
